// File: rtl/ft_register_file.sv
// Fault-tolerant 32-entry register file: duplicated copies with per-copy parity,
// read-time correction and a single-entry repair writeback. Optional FT_INJECT_EN adds fault-injection inputs.
module ft_register_file #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        A1,
    input  logic [4:0]        A2,
    input  logic [4:0]        A3,
    input  logic [DATA_W-1:0] WD3,
    input  logic              WE3,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              error_detected,
    output logic              uncorrectable,
    output logic              repair_busy,
    output logic [CNT_W-1:0]  err_count
`ifdef FT_INJECT_EN
    ,
    input  logic              inj_en,
    input  logic              inj_sel,
    input  logic [DATA_W-1:0] inj_mask
`endif
);

    typedef enum logic {IDLE, PEND} state_t;

    logic [DATA_W-1:0] copy_a_reg [32];
    logic [DATA_W-1:0] copy_b_reg [32];
    logic [31:0]       par_a_reg;
    logic [31:0]       par_b_reg;

    state_t            state_reg, state_next;
    logic [4:0]        rep_addr_reg, rep_addr_next;
    logic [DATA_W-1:0] rep_data_reg, rep_data_next;
    logic              repair_fire;
    logic              write_hit;
    logic              uncorrectable_reg;
    logic [CNT_W-1:0]  err_count_reg;

    // One resolver per read port; port_g[0] serves A1, port_g[1] serves A2.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : port_g
            logic [4:0]        addr;
            logic [DATA_W-1:0] val_a;
            logic [DATA_W-1:0] val_b;
            logic [DATA_W-1:0] data;
            logic              ok_a;
            logic              ok_b;
            logic              mism;
            logic              corr;
            logic              unc;

            assign addr  = (gi == 0) ? A1 : A2;
            assign val_a = copy_a_reg[addr];
            assign val_b = copy_b_reg[addr];
            assign ok_a  = ((^val_a) == par_a_reg[addr]);
            assign ok_b  = ((^val_b) == par_b_reg[addr]);
            assign mism  = (addr != 5'd0) && (val_a != val_b);
            assign corr  = mism && (ok_a != ok_b);
            assign unc   = mism && (ok_a == ok_b);
            // Copy B is only trusted when it alone passes parity.
            assign data  = (addr == 5'd0) ? '0 :
                           (mism && ok_b && !ok_a) ? val_b : val_a;
        end
    endgenerate

    assign RD1            = port_g[0].data;
    assign RD2            = port_g[1].data;
    assign error_detected = port_g[0].mism | port_g[1].mism;
    assign uncorrectable  = uncorrectable_reg;
    assign repair_busy    = (state_reg == PEND);
    assign err_count      = err_count_reg;
    assign write_hit      = WE3 && (A3 != 5'd0);

    always_comb begin
        state_next    = state_reg;
        rep_addr_next = rep_addr_reg;
        rep_data_next = rep_data_reg;
        repair_fire   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (port_g[0].corr) begin
                    state_next    = PEND;
                    rep_addr_next = A1;
                    rep_data_next = port_g[0].data;
                end else if (port_g[1].corr) begin
                    state_next    = PEND;
                    rep_addr_next = A2;
                    rep_data_next = port_g[1].data;
                end
            end
            PEND: begin
                // The repair only uses the write port when the pipeline leaves it idle.
                if (!WE3) begin
                    repair_fire = 1'b1;
                    state_next  = IDLE;
                end else if (A3 == rep_addr_reg) begin
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef FT_INJECT_EN
    logic [DATA_W-1:0] inj_base_a;
    logic [DATA_W-1:0] inj_base_b;

    // Injection lands on top of whatever this edge writes into the same entry.
    always_comb begin
        inj_base_a = copy_a_reg[A3];
        inj_base_b = copy_b_reg[A3];
        if (write_hit) begin
            inj_base_a = WD3;
            inj_base_b = WD3;
        end else if (repair_fire && (rep_addr_reg == A3)) begin
            inj_base_a = rep_data_reg;
            inj_base_b = rep_data_reg;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                copy_a_reg[i] <= '0;
                copy_b_reg[i] <= '0;
            end
            par_a_reg <= '0;
            par_b_reg <= '0;
        end else begin
            if (repair_fire) begin
                copy_a_reg[rep_addr_reg] <= rep_data_reg;
                copy_b_reg[rep_addr_reg] <= rep_data_reg;
                par_a_reg[rep_addr_reg]  <= ^rep_data_reg;
                par_b_reg[rep_addr_reg]  <= ^rep_data_reg;
            end
            if (write_hit) begin
                copy_a_reg[A3] <= WD3;
                copy_b_reg[A3] <= WD3;
                par_a_reg[A3]  <= ^WD3;
                par_b_reg[A3]  <= ^WD3;
            end
`ifdef FT_INJECT_EN
            if (inj_en && (A3 != 5'd0)) begin
                if (!inj_sel) begin
                    copy_a_reg[A3] <= inj_base_a ^ inj_mask;
                end else begin
                    copy_b_reg[A3] <= inj_base_b ^ inj_mask;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            rep_addr_reg      <= '0;
            rep_data_reg      <= '0;
            uncorrectable_reg <= 1'b0;
            err_count_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            rep_addr_reg <= rep_addr_next;
            rep_data_reg <= rep_data_next;
            if (port_g[0].unc || port_g[1].unc) begin
                uncorrectable_reg <= 1'b1;
            end
            if (error_detected && (err_count_reg != '1)) begin
                err_count_reg <= err_count_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ft_register_file.sv
// Randomized and directed bench for ft_register_file against a behavioural model;
// fault-injection scenarios run only when FT_INJECT_EN is defined.
module tb_ft_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  a1, a2, a3;
    logic [31:0] wd3;
    logic        we3;
    logic        inj_en, inj_sel;
    logic [31:0] inj_mask;
    logic [31:0] rd1, rd2;
    logic        error_detected, uncorrectable, repair_busy;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    ft_register_file #(.DATA_W(32), .CNT_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .A1             (a1),
        .A2             (a2),
        .A3             (a3),
        .WD3            (wd3),
        .WE3            (we3),
        .RD1            (rd1),
        .RD2            (rd2),
        .error_detected (error_detected),
        .uncorrectable  (uncorrectable),
        .repair_busy    (repair_busy),
        .err_count      (err_count)
`ifdef FT_INJECT_EN
        ,
        .inj_en         (inj_en),
        .inj_sel        (inj_sel),
        .inj_mask       (inj_mask)
`endif
    );

    // Behavioural model: two copies, their stored parity, one pending repair slot.
    logic [31:0] m_a [32];
    logic [31:0] m_b [32];
    bit          m_pa [32];
    bit          m_pb [32];
    bit          m_pend;
    logic [4:0]  m_rep_addr;
    logic [31:0] m_rep_data;
    bit          m_unc;
    int          m_cnt;
    bit          m_valid = 1'b0;

    logic [31:0] s_rd1, s_rd2;
    logic        s_ed, s_unc, s_busy;
    logic [7:0]  s_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic bit odd(input logic [31:0] v);
        return ($countones(v) % 2) == 1;
    endfunction

    function automatic void resolve(input logic [4:0] addr, output logic [31:0] data,
                                    output bit mism, output bit corr, output bit unc);
        bit ok_a, ok_b;
        data = 32'd0; mism = 0; corr = 0; unc = 0;
        if (addr != 0) begin
            ok_a = (odd(m_a[addr]) == m_pa[addr]);
            ok_b = (odd(m_b[addr]) == m_pb[addr]);
            data = m_a[addr];
            if (m_a[addr] != m_b[addr]) begin
                mism = 1;
                if (ok_a && !ok_b) corr = 1;
                else if (ok_b && !ok_a) begin corr = 1; data = m_b[addr]; end
                else unc = 1;
            end
        end
    endfunction

    task automatic step(input bit r, input logic [4:0] ra1, input logic [4:0] ra2,
                        input logic [4:0] wa, input logic [31:0] wd, input bit we,
                        input bit ie, input bit isel, input logic [31:0] imask,
                        input string tag);
        logic [31:0] d1, d2;
        bit m1, c1, u1, m2, c2, u2, ie_eff;
`ifdef FT_INJECT_EN
        ie_eff = ie;
`else
        ie_eff = 1'b0;
`endif
        rst = r; a1 = ra1; a2 = ra2; a3 = wa; wd3 = wd; we3 = we;
        inj_en = ie_eff; inj_sel = isel; inj_mask = imask;
        @(negedge clk);
        s_rd1 = rd1; s_rd2 = rd2; s_ed = error_detected;
        s_unc = uncorrectable; s_busy = repair_busy; s_cnt = err_count;
        resolve(ra1, d1, m1, c1, u1);
        resolve(ra2, d2, m2, c2, u2);
        if (m_valid) begin
            check({tag, ".rd1"}, s_rd1, d1);
            check({tag, ".rd2"}, s_rd2, d2);
            check({tag, ".err"}, s_ed, m1 | m2);
            check({tag, ".unc"}, s_unc, m_unc);
            check({tag, ".busy"}, s_busy, m_pend);
            check({tag, ".cnt"}, s_cnt, m_cnt);
        end
        $display("step %s rst=%0d a1=%0d a2=%0d a3=%0d we=%0d wd=%h inj=%0d rd1=%h rd2=%h err=%0d unc=%0d busy=%0d cnt=%0d",
                 tag, r, ra1, ra2, wa, we, wd, ie_eff, s_rd1, s_rd2, s_ed, s_unc, s_busy, s_cnt);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) begin
                m_a[i] = 0; m_b[i] = 0; m_pa[i] = 0; m_pb[i] = 0;
            end
            m_pend = 0; m_rep_addr = 0; m_rep_data = 0; m_unc = 0; m_cnt = 0;
            m_valid = 1;
        end else begin
            if ((m1 | m2) && m_cnt < 255) m_cnt++;
            if (u1 | u2) m_unc = 1;
            if (m_pend && !we) begin
                m_a[m_rep_addr] = m_rep_data; m_b[m_rep_addr] = m_rep_data;
                m_pa[m_rep_addr] = odd(m_rep_data); m_pb[m_rep_addr] = odd(m_rep_data);
            end
            if (we && wa != 0) begin
                m_a[wa] = wd; m_b[wa] = wd; m_pa[wa] = odd(wd); m_pb[wa] = odd(wd);
            end
            if (ie_eff && wa != 0) begin
                if (!isel) m_a[wa] = m_a[wa] ^ imask;
                else m_b[wa] = m_b[wa] ^ imask;
            end
            if (!m_pend) begin
                if (c1) begin m_pend = 1; m_rep_addr = ra1; m_rep_data = d1; end
                else if (c2) begin m_pend = 1; m_rep_addr = ra2; m_rep_data = d2; end
            end else if (!we || wa == m_rep_addr) begin
                m_pend = 0;
            end
        end
        #1;
    endtask

    initial begin
        logic [31:0] msk;
        rst = 1; a1 = 0; a2 = 0; a3 = 0; wd3 = 0; we3 = 0;
        inj_en = 0; inj_sel = 0; inj_mask = 0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        step(0, 0, 0, 5, 32'hDEADBEEF, 1, 0, 0, 0, "wr_x5");
        step(0, 5, 0, 0, 0, 0, 0, 0, 0, "rd_x5");
        check("basic_rd1", s_rd1, 32'hDEADBEEF);
        check("basic_rd2", s_rd2, 32'h0);
        check("basic_err", s_ed, 1'b0);
        check("basic_cnt", s_cnt, 8'd0);

        step(0, 0, 0, 0, 32'hFFFFFFFF, 1, 0, 0, 0, "wr_x0");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, "rd_x0");
        check("x0_rd1", s_rd1, 32'h0);
        step(0, 7, 7, 7, 32'h12, 1, 0, 0, 0, "wr_x7_rd");
        check("nobypass_old", s_rd1, 32'h0);
        step(0, 7, 0, 0, 0, 0, 0, 0, 0, "rd_x7");
        check("nobypass_new", s_rd1, 32'h12);

`ifdef FT_INJECT_EN
        step(0, 0, 0, 3, 32'h000000F0, 1, 0, 0, 0, "wr_x3");
        step(0, 0, 0, 3, 0, 0, 1, 0, 32'h1, "inj_x3a");
        step(0, 3, 0, 0, 0, 0, 0, 0, 0, "detect_x3");
        check("corr_rd1", s_rd1, 32'h000000F0);
        check("corr_err", s_ed, 1'b1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, "repair_x3");
        check("corr_busy", s_busy, 1'b1);
        step(0, 3, 0, 0, 0, 0, 0, 0, 0, "after_repair");
        check("repaired_err", s_ed, 1'b0);
        check("repaired_cnt", s_cnt, 8'd1);

        step(0, 0, 0, 3, 0, 0, 1, 0, 32'h1, "inj_x3b");
        step(0, 3, 0, 0, 0, 0, 0, 0, 0, "detect_x3b");
        step(0, 0, 0, 3, 32'hAAAA5555, 1, 0, 0, 0, "supersede");
        step(0, 3, 0, 0, 0, 0, 0, 0, 0, "after_supersede");
        check("sup_rd1", s_rd1, 32'hAAAA5555);
        check("sup_err", s_ed, 1'b0);
        check("sup_busy", s_busy, 1'b0);

        step(0, 0, 0, 9, 32'h0, 1, 0, 0, 0, "wr_x9");
        step(0, 0, 0, 9, 0, 0, 1, 0, 32'h3, "inj_x9");
        step(0, 9, 0, 0, 0, 0, 0, 0, 0, "unc_x9");
        check("unc_rd1", s_rd1, 32'h3);
        check("unc_err", s_ed, 1'b1);
        for (int i = 0; i < 300; i++) step(0, 9, 0, 0, 0, 0, 0, 0, 0, "hold_unc");
        check("unc_sticky", s_unc, 1'b1);
        check("sat_cnt", s_cnt, 8'd255);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset2");
        step(0, 9, 0, 0, 0, 0, 0, 0, 0, "post_reset");
        check("rst_cnt", s_cnt, 8'd0);
        check("rst_unc", s_unc, 1'b0);
        check("rst_rd1", s_rd1, 32'h0);
`endif

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 2))
                0: msk = 32'h1 << $urandom_range(0, 31);
                1: msk = (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31));
                default: msk = $urandom;
            endcase
            step(($urandom_range(0, 99) == 0),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 $urandom, bit'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) == 0), bit'($urandom_range(0, 1)), msk, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
